// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the byte-serial memory arbiter.
package mem_arb_pkg;
  localparam int BEATS          = 4;
  localparam int BEAT_W         = 2;
  localparam int ADDR_W_DEF     = 16;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    TAIL,
    ACK
  } state_t;
endpackage

// File: rtl/mem_byte_pack.sv
// Big-endian byte assembly: three captured bytes plus the live read byte.
module mem_byte_pack (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cap,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word
);
  logic [23:0] r_sh;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sh <= '0;
    end else if (i_cap) begin
      r_sh <= {r_sh[15:0], i_byte};
    end
  end

  assign o_word = {r_sh, i_byte};
endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto a byte-wide synchronous memory,
// moving one 32-bit word per grant as four big-endian beats.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              mem_Clk,
  input  logic              mem_Rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_ack,
  output logic [31:0]       dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wbyte,
  input  logic [7:0]        mem_rbyte,
  output logic              busy
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [BEAT_W-1:0] LAST = BEAT_W'(BEATS - 1);

  state_t              r_state;
  state_t              w_nxt;
  logic [BEAT_W-1:0]   r_beat;
  logic [SW-1:0]       r_starve;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic                r_fetch;
  logic [31:0]         r_wdata;
  logic [31:0]         r_if_rdata;
  logic [31:0]         r_dm_rdata;
  logic                w_accept;
  logic                w_grant_if;
  logic                w_cap;
  logic [31:0]         w_word;
  logic [7:0]          w_wbyte;
  logic                w_unused;

  assign w_unused = &{1'b0, if_addr[31:ADDR_W], dm_addr[31:ADDR_W]};

  assign w_grant_if = if_req && (!dm_req || r_starve == STARVE_LIM);
  assign w_accept   = (r_state == IDLE) && (if_req || dm_req);

  always_ff @(posedge mem_Clk) begin
    if (!mem_Rst_n) r_state <= IDLE;
    else            r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nxt = XFER;
      XFER:    if (r_beat == LAST) w_nxt = TAIL;
      TAIL:    w_nxt = ACK;
      ACK:     w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mem_Clk) begin
    if (!mem_Rst_n) begin
      r_beat     <= '0;
      r_starve   <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_fetch    <= 1'b0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_beat <= (r_state == XFER) ? r_beat + 1'b1 : '0;
      if (r_state == IDLE) begin
        if (!if_req) r_starve <= '0;
        if (w_accept) begin
          r_fetch <= w_grant_if;
          r_addr  <= w_grant_if ? if_addr[ADDR_W-1:0]
                                : dm_addr[ADDR_W-1:0];
          r_we    <= !w_grant_if && dm_we;
          r_wdata <= dm_wdata;
          if (w_grant_if)
            r_starve <= '0;
          else if (if_req && r_starve != STARVE_LIM)
            r_starve <= r_starve + 1'b1;
        end
      end
      // TAIL carries the final read byte; the word is complete here
      if (r_state == TAIL && !r_we) begin
        if (r_fetch) r_if_rdata <= w_word;
        else         r_dm_rdata <= w_word;
      end
    end
  end

  assign w_cap = (r_state == TAIL) ||
                 (r_state == XFER && r_beat != '0);

  mem_byte_pack u_pack (
    .i_clk   (mem_Clk),
    .i_rst_n (mem_Rst_n),
    .i_cap   (w_cap),
    .i_byte  (mem_rbyte),
    .o_word  (w_word)
  );

  always_comb begin
    w_wbyte = '0;
    unique case (r_beat)
      2'd0: w_wbyte = r_wdata[31:24];
      2'd1: w_wbyte = r_wdata[23:16];
      2'd2: w_wbyte = r_wdata[15:8];
      2'd3: w_wbyte = r_wdata[7:0];
    endcase
  end

  // Write strobe also drops on a low reset so an aborted beat never lands
  assign mem_we    = (r_state == XFER) && r_we && mem_Rst_n;
  assign mem_wbyte = (r_state == XFER && r_we) ? w_wbyte : '0;
  assign mem_addr  = (r_state == XFER) ? r_addr + ADDR_W'(r_beat) : '0;
  assign if_ack    = (r_state == ACK) && r_fetch;
  assign dm_ack    = (r_state == ACK) && !r_fetch;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign busy      = (r_state != IDLE);
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the byte-address width of the shared byte memory.
REQ-002 Parameter STARVE_MAX, default 4, SHALL set the consecutive fetch losses after which fetch wins.
REQ-003 mem_Clk  in  1  SHALL be the single clock; all logic updates on its rising edge.
REQ-004 mem_Rst_n  in  1  SHALL be the reset: synchronous, active-low.
REQ-005 if_req  in  1: instruction-fetch request, held until if_ack.
REQ-006 if_addr  in  32: fetch byte address.
REQ-007 if_ack  out  1: one-cycle fetch completion pulse.
REQ-008 if_rdata  out  32: fetched word.
REQ-009 dm_req  in  1: data request, held until dm_ack.
REQ-010 dm_we  in  1: 1 = store, 0 = load.
REQ-011 dm_addr  in  32: data byte address.
REQ-012 dm_wdata  in  32: store word.
REQ-013 dm_ack  out  1: one-cycle data completion pulse.
REQ-014 dm_rdata  out  32: load word.
REQ-015 mem_addr  out  ADDR_W: byte address to the memory.
REQ-016 mem_we  out  1: byte write enable.
REQ-017 mem_wbyte  out  8: write byte.
REQ-018 mem_rbyte  in  8: read byte, valid one cycle after mem_addr is presented (synchronous read).
REQ-019 busy  out  1: high whenever the state is not IDLE.

Function
REQ-020 The FSM SHALL use states IDLE, XFER, TAIL, ACK: IDLE->XFER on acceptance; XFER stays 4 cycles (beat counter 0..3); XFER->TAIL; TAIL->ACK; ACK->IDLE.
REQ-021 Acceptance SHALL occur only in IDLE with at least one request high; the winner's addr, we and wdata SHALL be latched at acceptance.
REQ-022 Arbitration: data wins a simultaneous request unless the starve counter equals STARVE_MAX, in which case fetch wins.
REQ-023 The starve counter SHALL increment when data is accepted while if_req is high, saturate at STARVE_MAX, and clear when fetch is accepted or if_req is low in IDLE.
REQ-024 In XFER, mem_addr SHALL be latched_addr[ADDR_W-1:0] + beat, wrapping modulo 2**ADDR_W; upper address bits are ignored; misaligned addresses are legal.
REQ-025 Byte order SHALL be big-endian: beat 0 carries bits 31:24 and beat 3 carries bits 7:0.
REQ-026 For a store, mem_we SHALL be high in exactly the 4 XFER cycles with mem_wbyte = the corresponding wdata byte; it is low in every other state.
REQ-027 For a read, mem_rbyte SHALL be captured one cycle after each beat, the last capture occurring in TAIL.
REQ-028 The winner's ack SHALL pulse high for exactly one cycle in ACK: 6 cycles after the acceptance cycle. Load and fetch words SHALL be valid in that cycle.
REQ-029 if_rdata and dm_rdata SHALL hold their last completed value until their next read completes. A store SHALL leave dm_rdata unchanged.
REQ-030 Requests arriving outside IDLE SHALL wait. Peak throughput is one transfer per 7 cycles.
REQ-031 A requester dropping its request after acceptance SHALL NOT abort the transfer; ack is still issued.
REQ-032 A low if_req stalls fetch indefinitely; data transfers continue unaffected.

Reset
REQ-033 While mem_Rst_n is low at an edge: state IDLE, beat 0, starve 0, acks 0, mem_we 0, mem_addr 0, mem_wbyte 0, rdata outputs 0, busy 0.
REQ-034 Reset mid-transfer SHALL abort with no ack. Bytes already written stay written. mem_we SHALL be low from the reset edge.

Structure
REQ-035 Package mem_arb_pkg SHALL hold the state enum, BEATS=4 and the ADDR_W/STARVE_MAX defaults.
REQ-036 The beat shift/assembly register SHALL be the sub-module mem_byte_pack. Arbitration and the FSM SHALL remain in mem_arbiter.

Verification
REQ-037 Fetch at 0x0000 with memory bytes 12 34 56 78 -> mem_addr 0,1,2,3, then if_ack 6 cycles after acceptance with if_rdata=0x12345678.
REQ-038 Store 0xDEADBEEF to 0x0010, then load 0x0010 -> mem_we on 0x10..0x13 with bytes DE AD BE EF, then dm_rdata=0xDEADBEEF.
REQ-039 if_req and dm_req both held continuously -> grant order D,D,D,D,F,D,D,D,D,F, and no ack ever coincides with the other port's ack.
REQ-040 Store 0x01020304 to 0xFFFE -> writes go to 0xFFFE, 0xFFFF, 0x0000, 0x0001 in that order.
REQ-041 mem_Rst_n low during beat 2 of a store -> only bytes 0..1 are written, no dm_ack, and outputs take their reset values on the next edge.
REQ-042 if_req low for 20 cycles, then high -> no memory activity and busy=0 throughout; the fetch completes 6 cycles after acceptance.
